instr_fetch_unit: RTL and testbench

- Sequential fetch stage directly upstream of the main control decoder.
- Owns the PC register and runs a request/response handshake with instruction memory.
- Holds the fetched 32-bit instruction stable until the downstream stage accepts it; instr[6:0] drives the decoder's op input.
- Next PC after each accepted instruction is PC+4 or a branch/jump target, and the pipeline can be flushed to a new PC at any time.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-stage bundle, imem request/response on one side, decoder handshake on the other.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            fetch_fault;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, fetch_fault,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_target, flush, flush_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc, pc_plus4, fetch_fault,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_target, flush, flush_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and imem request/response FSM feeding the decoder.
// FETCH_ALIGN_CHECK_EN adds a terminal FAULT state for misaligned targets; otherwise targets are word-aligned.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.master bus
);
`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
  localparam state_t FAULT_ST = FAULT;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam state_t FAULT_ST = REQ;
`endif
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, flush_tgt, redir_tgt;
  logic kill_q, kill_d, flush_bad, redir_bad;
`ifdef FETCH_ALIGN_CHECK_EN
  assign flush_tgt       = bus.flush_pc;
  assign redir_tgt       = bus.redirect_target;
  assign flush_bad       = |bus.flush_pc[1:0];
  assign redir_bad       = |bus.redirect_target[1:0];
  assign bus.fetch_fault = state_q == FAULT;
`else
  assign flush_tgt       = bus.flush_pc & ~XLEN'(3);
  assign redir_tgt       = bus.redirect_target & ~XLEN'(3);
  assign flush_bad       = 1'b0;
  assign redir_bad       = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif
  assign bus.imem_req    = state_q == REQ;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = state_q == HOLD;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + XLEN'(4);
  // kill marks one in-flight response that must be swallowed; any response retires it
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    kill_d  = kill_q & ~bus.imem_rvalid;
    if (bus.flush) begin
      pc_d    = flush_tgt;
      instr_d = NOP_INSTR;
      kill_d  = kill_d | (state_q == REQ && bus.imem_ready) | (state_q == WAIT && !bus.imem_rvalid);
      state_d = flush_bad ? FAULT_ST :
                (state_q == REQ && !bus.imem_ready) ? REQ :
                (state_q == REQ || (state_q == WAIT && !bus.imem_rvalid)) ? WAIT : REQ;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = bus.imem_ready ? WAIT : REQ;
        WAIT: if (bus.imem_rvalid) begin
          state_d = kill_q ? REQ : HOLD;
          instr_d = kill_q ? instr_q : bus.imem_rdata;
        end
        HOLD: if (bus.instr_ready) begin
          pc_d    = bus.redirect ? redir_tgt : pc_q + XLEN'(4);
          instr_d = NOP_INSTR;
          state_d = (bus.redirect && redir_bad) ? FAULT_ST : REQ;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      kill_q  <= kill_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors, corner sequences and a randomized run against a PC-sequence model.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  instr_fetch_unit_if #(.XLEN(32)) bus();
  instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start, exp_pc, data;
    logic        rd;
    logic [31:0] tgt, exp_next;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.instr_ready = 0; bus.redirect = 0; bus.redirect_target = 0;
    bus.flush = 0; bus.flush_pc = 0;
  endtask

  task automatic wait_req;
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      tick;
      n++;
    end
    chk("req_timeout", 32'(bus.imem_req), 1);
  endtask

  task automatic fetch(input logic [31:0] d);
    wait_req;
    bus.imem_ready = 1;
    tick;
    bus.imem_ready = 0;
    chk("wait_req_low", 32'(bus.imem_req), 0);
    bus.imem_rvalid = 1;
    bus.imem_rdata = d;
    tick;
    bus.imem_rvalid = 0;
    chk("fetch_valid", 32'(bus.instr_valid), 1);
    chk("fetch_instr", bus.instr, d);
  endtask

  task automatic accept(input logic rd, input logic [31:0] t);
    bus.instr_ready = 1; bus.redirect = rd; bus.redirect_target = t;
    tick;
    bus.instr_ready = 0; bus.redirect = 0;
  endtask

  task automatic do_flush(input logic [31:0] a);
    bus.flush = 1; bus.flush_pc = a;
    tick;
    bus.flush = 0;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v[6];
    int nv;
    logic [31:0] model_pc, paddr, fpc, tgt, o_addr, o_pc;
    logic pending, fl, rdy, rd, ir, o_req, o_valid;
    int delay, n_deliv;
    v[0] = '{32'h0000_1000, 32'h0000_1000, 32'h0050_0093, 1'b0, 32'h0,         32'h0000_1004};
    v[1] = '{32'h0000_1000, 32'h0000_1000, 32'h1234_5678, 1'b1, 32'h0000_0100, 32'h0000_0100};
    v[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_006F, 1'b0, 32'h0,         32'h0000_0000};
    v[3] = '{32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h1357_9BDF, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    v[4] = '{32'h0000_0080, 32'h0000_0080, 32'hABCD_0000, 1'b1, 32'h0000_0102, 32'h0000_0100};
    v[5] = '{32'h0000_0203, 32'h0000_0200, 32'h0F0F_0F0F, 1'b0, 32'h0,         32'h0000_0204};
`ifdef FETCH_ALIGN_CHECK_EN
    nv = 4;
`else
    nv = 6;
`endif
    idle_in;
    #12;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_pc", bus.pc, 0);
    chk("rst_pc4", bus.pc_plus4, 4);
    chk("rst_fault", 32'(bus.fetch_fault), 0);
    @(negedge clk);
    reset = 0;
    tick;
    chk("first_req", 32'(bus.imem_req), 1);
    chk("first_addr", bus.imem_addr, 0);
    bus.imem_ready = 1;
    tick;
    bus.imem_ready = 0;
    chk("lat_wait_valid", 32'(bus.instr_valid), 0);
    bus.imem_rvalid = 1;
    bus.imem_rdata = 32'h0050_0093;
    tick;
    bus.imem_rvalid = 0;
    chk("lat_valid", 32'(bus.instr_valid), 1);
    chk("lat_instr", bus.instr, 32'h0050_0093);
    chk("lat_pc", bus.pc, 0);
    accept(0, 0);
    chk("seq_addr4", bus.imem_addr, 4);
    fetch(32'h00A0_0113);
    bus.redirect = 1;
    bus.redirect_target = 32'h500;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", 32'(bus.instr_valid), 1);
      chk("stall_instr", bus.instr, 32'h00A0_0113);
      chk("stall_pc", bus.pc, 4);
      chk("stall_req", 32'(bus.imem_req), 0);
    end
    accept(1, 32'h100);
    chk("redir_addr", bus.imem_addr, 32'h100);
    for (int i = 0; i < 4; i++) begin
      bus.imem_rvalid = (i == 1);
      bus.imem_rdata = 32'hBAD0_BAD0;
      tick;
      chk("reqhold_req", 32'(bus.imem_req), 1);
      chk("reqhold_addr", bus.imem_addr, 32'h100);
      chk("reqhold_valid", 32'(bus.instr_valid), 0);
    end
    bus.imem_rvalid = 0;
    fetch(32'h2222_2222);
    chk("reqhold_pc", bus.pc, 32'h100);
    accept(0, 0);
    bus.imem_ready = 1;
    tick;
    bus.imem_ready = 0;
    do_flush(32'h200);
    chk("fw_valid", 32'(bus.instr_valid), 0);
    chk("fw_req", 32'(bus.imem_req), 0);
    chk("fw_pc", bus.pc, 32'h200);
    bus.imem_rvalid = 1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick;
    bus.imem_rvalid = 0;
    chk("stale_valid", 32'(bus.instr_valid), 0);
    chk("stale_req", 32'(bus.imem_req), 1);
    chk("stale_addr", bus.imem_addr, 32'h200);
    fetch(32'h3333_3333);
    chk("post_flush_pc", bus.pc, 32'h200);
    bus.instr_ready = 1; bus.redirect = 1; bus.redirect_target = 32'h700;
    do_flush(32'h240);
    bus.instr_ready = 0; bus.redirect = 0;
    chk("fh_addr", bus.imem_addr, 32'h240);
    chk("fh_req", 32'(bus.imem_req), 1);
    chk("fh_valid", 32'(bus.instr_valid), 0);
    chk("fh_instr", bus.instr, NOP);
    for (int i = 0; i < nv; i++) begin
      do_flush(v[i].start);
      chk("vec_addr", bus.imem_addr, v[i].exp_pc);
      fetch(v[i].data);
      chk("vec_pc", bus.pc, v[i].exp_pc);
      chk("vec_pc4", bus.pc_plus4, v[i].exp_pc + 32'd4);
      accept(v[i].rd, v[i].tgt);
      chk("vec_next_req", 32'(bus.imem_req), 1);
      chk("vec_next_addr", bus.imem_addr, v[i].exp_next);
    end
    bus.imem_ready = 1;
    tick;
    bus.imem_ready = 0;
    #2;
    reset = 1;
    #1;
    chk("arst_req", 32'(bus.imem_req), 0);
    chk("arst_valid", 32'(bus.instr_valid), 0);
    chk("arst_pc", bus.pc, 0);
    chk("arst_instr", bus.instr, NOP);
    chk("arst_fault", 32'(bus.fetch_fault), 0);
    @(negedge clk);
    reset = 0;
    tick;
    chk("arst_restart", bus.imem_addr, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    fetch(32'h4444_4444);
    accept(1, 32'h102);
    chk("fault_flag", 32'(bus.fetch_fault), 1);
    chk("fault_pc", bus.pc, 32'h102);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("fault_req", 32'(bus.imem_req), 0);
      chk("fault_valid", 32'(bus.instr_valid), 0);
    end
    do_flush(32'h300);
    chk("unfault_flag", 32'(bus.fetch_fault), 0);
    chk("unfault_addr", bus.imem_addr, 32'h300);
    fetch(32'h5555_5555);
    accept(0, 0);
`endif
    do_flush(32'h4000);
    model_pc = 32'h4000;
    pending = 0;
    delay = 0;
    paddr = 0;
    n_deliv = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("r_pc", bus.pc, model_pc);
      chk("r_pc4", bus.pc_plus4, model_pc + 32'd4);
      chk("r_addr", bus.imem_addr, model_pc);
      chk("r_fault", 32'(bus.fetch_fault), 0);
      chk("r_instr", bus.instr, bus.instr_valid ? memf(model_pc) : NOP);
      chk("r_req_and_valid", 32'(bus.imem_req & bus.instr_valid), 0);
      o_req = bus.imem_req; o_addr = bus.imem_addr; o_valid = bus.instr_valid; o_pc = bus.pc;
      fl = ($urandom_range(0, 24) == 0);
      fpc = $urandom_range(0, 4095) << 2;
      rdy = 1'($urandom_range(0, 1));
      ir = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom_range(0, 4095) << 2);
      if (pending && delay == 0) begin
        bus.imem_rvalid = 1; bus.imem_rdata = memf(paddr);
      end else if (!pending) begin
        bus.imem_rvalid = ($urandom_range(0, 7) == 0); bus.imem_rdata = $urandom;
      end else begin
        bus.imem_rvalid = 0;
      end
      bus.flush = fl; bus.flush_pc = fpc; bus.imem_ready = rdy;
      bus.instr_ready = ir; bus.redirect = rd; bus.redirect_target = tgt;
      tick;
      if (fl) model_pc = fpc;
      else if (o_valid && ir) begin
        model_pc = rd ? tgt : o_pc + 32'd4;
        n_deliv++;
      end
      if (pending && delay == 0) pending = 0;
      else if (pending) delay--;
      if (o_req && rdy) begin
        pending = 1; paddr = o_addr; delay = $urandom_range(0, 3);
      end
    end
    idle_in;
    chk("r_deliveries", 32'(n_deliv > 50), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
